// File: rtl/prioritized_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prioritized_pkg
// Purpose  : Shared types for the prioritized mux/dispatcher family.
// Revision : 1.0 - initial release
// ============================================================================
package prioritized_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } dispatch_state_t;

endpackage
`default_nettype wire

// File: rtl/prioritized_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module   : prioritized_dispatcher_if
// Purpose  : Input stream, per-destination outputs and flush handshake.
// Revision : 1.0 - initial release
// ============================================================================
interface prioritized_dispatcher_if #(
    parameter int data_width        = 8,
    parameter int number_of_outputs = 4
);
    logic [data_width-1:0]        in_data;
    logic                         in_valid;
    logic                         in_ready;
    logic [number_of_outputs-1:0] out_enable;
    logic [data_width-1:0]        out_data [number_of_outputs];
    logic [number_of_outputs-1:0] out_valid;
    logic [number_of_outputs-1:0] out_ready;
    logic                         flush;
    logic                         flush_done;

    // Environment side: producer, consumers and flush controller
    modport master (
        output in_data, in_valid, out_enable, out_ready, flush,
        input  in_ready, out_data, out_valid, flush_done
    );

    // Dispatcher side
    modport slave (
        input  in_data, in_valid, out_enable, out_ready, flush,
        output in_ready, out_data, out_valid, flush_done
    );
endinterface
`default_nettype wire

// File: rtl/priority_one_hot.sv
`default_nettype none
// ============================================================================
// Module   : priority_one_hot
// Purpose  : Lowest-index-wins one-hot select; all-zero in gives all-zero out.
// Revision : 1.0 - initial release
// ============================================================================
module priority_one_hot #(
    parameter int width = 4
) (
    input  wire logic [width-1:0] i_req,
    output logic      [width-1:0] o_grant
);

    // Two's complement isolates the lowest set bit.
    assign o_grant = i_req & (~i_req + width'(1));

endmodule
`default_nettype wire

// File: rtl/prioritized_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : prioritized_dispatcher
// Purpose  : One stream fanned out to the lowest free enabled output register.
// Revision : 1.0 - initial release
// ============================================================================
module prioritized_dispatcher
    import prioritized_pkg::*;
#(
    parameter int data_width        = 8,
    parameter int number_of_outputs = 4
) (
    input wire logic                 clk,
    input wire logic                 rst_n,
    prioritized_dispatcher_if.slave  bus
);

    dispatch_state_t              r_state;
    dispatch_state_t              w_state_next;
    logic [number_of_outputs-1:0] w_valid;
    logic [number_of_outputs-1:0] w_free;
    logic [number_of_outputs-1:0] w_target;
    logic [number_of_outputs-1:0] w_load;
    logic                         w_in_ready;
    logic                         w_accept;

    // A full port is still free when its word leaves this same cycle.
    assign w_free = bus.out_enable & (~w_valid | bus.out_ready);

    priority_one_hot #(
        .width (number_of_outputs)
    ) u_target (
        .i_req   (w_free),
        .o_grant (w_target)
    );

    assign w_in_ready = rst_n && (r_state == RUN) && !bus.flush && (|w_free);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_load     = w_target & {number_of_outputs{w_accept}};

    generate
        for (genvar g = 0; g < number_of_outputs; g++) begin : g_port
            logic                  r_valid;
            logic [data_width-1:0] r_data;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end else if (w_load[g]) begin
                    r_valid <= 1'b1;
                    r_data  <= bus.in_data;
                end else if (bus.out_ready[g]) begin
                    r_valid <= 1'b0;
                end
            end

            assign w_valid[g]      = r_valid;
            assign bus.out_data[g] = r_data;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:     if (bus.flush) w_state_next = DRAIN;
            DRAIN:   if (!(|w_valid)) w_state_next = DONE;
            DONE:    w_state_next = RUN;
            default: w_state_next = RUN;
        endcase
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_valid;
    assign bus.flush_done = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_prioritized_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_prioritized_dispatcher
// Purpose  : Directed and randomized checks of prioritized_dispatcher.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prioritized_dispatcher;

    localparam int c_n = 4;
    localparam int c_w = 8;

    logic clk;
    logic rst_n;

    prioritized_dispatcher_if #(.data_width(c_w), .number_of_outputs(c_n)) bus ();

    prioritized_dispatcher #(
        .data_width        (c_w),
        .number_of_outputs (c_n)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference: what each destination currently holds, and the words owed to it.
    bit             m_valid [c_n];
    logic [c_w-1:0] m_data  [c_n];
    logic [c_w-1:0] sb_q    [c_n][$];
    int             m_mode;          // 0 accepting, 1 draining, 2 drain finished
    int             accepted;
    int             delivered;
    int             fd_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    function automatic int first_free();
        for (int i = 0; i < c_n; i++)
            if (bus.out_enable[i] && (!m_valid[i] || bus.out_ready[i])) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < c_n; i++) begin
            m_valid[i] = 1'b0;
            m_data[i]  = '0;
            sb_q[i].delete();
        end
        m_mode    = 0;
        accepted  = 0;
        delivered = 0;
    endtask

    // Check current outputs against the reference, then advance one clock.
    task automatic step();
        int             tgt;
        bit             rdy_exp;
        bit             all_empty;
        logic [c_n-1:0] vexp;
        logic [c_n-1:0] or_s;
        bit             iv_s;
        bit             fl_s;
        logic [c_w-1:0] d_s;
        logic [c_w-1:0] od_s [c_n];
        #1;
        tgt     = first_free();
        rdy_exp = (m_mode == 0) && !bus.flush && (tgt >= 0);
        for (int i = 0; i < c_n; i++) vexp[i] = m_valid[i];
        check("in_ready", bus.in_ready, rdy_exp);
        check("flush_done", bus.flush_done, m_mode == 2);
        check("out_valid", bus.out_valid, vexp);
        for (int i = 0; i < c_n; i++)
            check($sformatf("out_data%0d", i), bus.out_data[i], m_data[i]);
        or_s = bus.out_ready;
        iv_s = bus.in_valid;
        fl_s = bus.flush;
        d_s  = bus.in_data;
        for (int i = 0; i < c_n; i++) od_s[i] = bus.out_data[i];
        @(posedge clk);
        all_empty = 1'b1;
        for (int i = 0; i < c_n; i++) if (m_valid[i]) all_empty = 1'b0;
        for (int i = 0; i < c_n; i++) begin
            if (m_valid[i] && or_s[i]) begin
                check("sb_occupied", sb_q[i].size() != 0, 1);
                if (sb_q[i].size() != 0) check("sb_word", od_s[i], sb_q[i].pop_front());
                delivered++;
                m_valid[i] = 1'b0;
            end
        end
        if (iv_s && rdy_exp) begin
            m_valid[tgt] = 1'b1;
            m_data[tgt]  = d_s;
            sb_q[tgt].push_back(d_s);
            accepted++;
        end
        case (m_mode)
            0:       if (fl_s) m_mode = 1;
            1:       if (all_empty) m_mode = 2;
            default: m_mode = 0;
        endcase
        @(negedge clk);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.in_data    = '0;
        bus.in_valid   = 1'b0;
        bus.out_enable = '0;
        bus.out_ready  = '0;
        bus.flush      = 1'b0;
        model_reset();
        fd_cnt = 0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_valid", bus.out_valid, 4'b0000);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_flush_done", bus.flush_done, 0);
        for (int i = 0; i < c_n; i++) check("rst_data", bus.out_data[i], 0);
        @(negedge clk);
        rst_n          = 1'b1;
        bus.out_enable = 4'b1111;
        #1;
        check("run_in_ready", bus.in_ready, 1);
        step();

        // Priority fill: four words land on ports 0..3, fifth stalls
        bus.in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            bus.in_data = 8'(k * 8'h11);
            step();
        end
        bus.in_data = 8'h55;
        #1;
        check("fill_stall", bus.in_ready, 0);
        step();
        for (int k = 0; k < 4; k++) check("fill_word", bus.out_data[k], 8'(8'h11 * (k + 1)));
        bus.out_ready = 4'b0100;
        step();
        bus.out_ready = 4'b0000;
        bus.in_valid  = 1'b0;
        step();
        check("fill_p2", bus.out_data[2], 8'h55);
        check("fill_valid", bus.out_valid, 4'b1111);

        // Same-cycle reload on port 0
        bus.out_ready = 4'b1111;
        step();
        bus.out_ready = 4'b0000;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hAA;
        step();
        bus.out_ready = 4'b0001;
        bus.in_data   = 8'hBB;
        step();
        bus.out_ready = 4'b0000;
        bus.in_valid  = 1'b0;
        step();
        check("reload_data", bus.out_data[0], 8'hBB);
        check("reload_valid", bus.out_valid, 4'b0001);
        bus.out_ready = 4'b1111;
        step();

        // Enable masking
        bus.out_ready  = 4'b0000;
        bus.out_enable = 4'b1010;
        bus.in_valid   = 1'b1;
        bus.in_data    = 8'h5A;
        step();
        bus.in_valid   = 1'b0;
        bus.out_enable = 4'b1000;
        step();
        step();
        check("mask_hold", bus.out_valid, 4'b0010);
        check("mask_data", bus.out_data[1], 8'h5A);
        bus.out_ready = 4'b0010;
        step();
        check("mask_drained", bus.out_valid, 4'b0000);
        bus.out_enable = 4'b0000;
        bus.in_valid   = 1'b1;
        #1;
        check("enable_zero", bus.in_ready, 0);
        step();

        // Flush with ports 1 and 3 occupied
        bus.out_ready  = 4'b0000;
        bus.out_enable = 4'b1010;
        bus.in_data    = 8'h61;
        step();
        bus.in_data    = 8'h63;
        step();
        bus.out_enable = 4'b1111;
        bus.in_data    = 8'h77;
        bus.flush      = 1'b1;
        #1;
        check("flush_block", bus.in_ready, 0);
        step();
        bus.flush = 1'b0;
        fd_cnt    = 0;
        for (int c = 1; c <= 12; c++) begin
            bus.out_ready = {(c >= 5), 1'b0, (c >= 3), 1'b0};
            step();
            if (bus.flush_done) fd_cnt++;
        end
        check("flush_pulses", fd_cnt, 1);
        check("flush_resume", bus.out_data[0], 8'h77);
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b1111;
        step();

        // Reset mid-operation with ports 0 and 2 valid
        bus.out_ready  = 4'b0000;
        bus.out_enable = 4'b0101;
        bus.in_valid   = 1'b1;
        bus.in_data    = 8'hC0;
        step();
        bus.in_data    = 8'hC2;
        step();
        check("pre_rst_valid", bus.out_valid, 4'b0101);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", bus.out_valid, 4'b0000);
        check("mid_rst_ready", bus.in_ready, 0);
        check("mid_rst_d0", bus.out_data[0], 0);
        check("mid_rst_d2", bus.out_data[2], 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Random soak
        for (int cyc = 0; cyc < 10000; cyc++) begin
            bus.in_valid   = ($urandom_range(0, 3) != 0);
            bus.in_data    = 8'($urandom);
            bus.out_enable = 4'($urandom);
            bus.out_ready  = 4'($urandom);
            bus.flush      = ($urandom_range(0, 199) == 0);
            step();
        end
        bus.in_valid   = 1'b0;
        bus.flush      = 1'b0;
        bus.out_enable = 4'b0000;
        bus.out_ready  = 4'b1111;
        for (int k = 0; k < 4; k++) step();
        check("conservation", accepted, delivered);
        for (int i = 0; i < c_n; i++) check("sb_empty", sb_q[i].size(), 0);
        check("soak_activity", accepted > 1000, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
